// File: rtl/sram_controller_pkg.sv
// sram_ctrl_pkg: shared state encoding, default widths and clog2 helper for the SRAM controller
package sram_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_PULSE  = 3'd2,
        WR_HOLD   = 3'd3,
        RD_ACCESS = 3'd4,
        RD_TURN   = 3'd5
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: host-side request/response handshake of the SRAM controller
interface sram_controller_if import sram_ctrl_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, wr_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, wr_done
    );
endinterface

// File: rtl/sram_controller_phase_timer.sv
// sram_phase_timer: loadable down-counter that stops at zero, timing write pulses and read accesses
module sram_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);
    logic [WIDTH-1:0] cnt;

    // load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sram_controller.sv
// sram_controller: single-request master sequencing ce_n/oe_n/we_n and the tri-state bus of an async SRAM
module sram_controller import sram_ctrl_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WR_CYCLES  = 2,
    parameter int RD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_controller_if.slave      host,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);
    localparam int CW = clog2(((WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES) + 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  data_oe;
    logic                  rd_valid_q;
    logic                  wr_done_q;
    logic                  accept;
    logic                  t_load;
    logic                  t_zero;
    logic [CW-1:0]         t_val;

    assign host.req_ready = (state == IDLE) && !rst;
    assign accept         = host.req_valid && host.req_ready;
    assign t_load         = (state == WR_SETUP) || (accept && !host.req_write);
    assign t_val          = (state == WR_SETUP) ? CW'(WR_CYCLES - 1) : CW'(RD_CYCLES - 1);
    assign sram_data      = data_oe ? wdata_q : 'z;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign host.wr_done   = wr_done_q;

    sram_phase_timer #(.WIDTH(CW)) timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // FSM with registered strobes: each transition sets the pin levels of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_addr  <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            data_oe    <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sram_addr <= host.req_addr;
                    wdata_q   <= host.req_wdata;
                    sram_ce_n <= 1'b0;
                    if (host.req_write) begin
                        state   <= WR_SETUP;
                        data_oe <= 1'b1;
                    end else begin
                        state     <= RD_ACCESS;
                        sram_oe_n <= 1'b0;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    sram_we_n <= 1'b0;
                end
                WR_PULSE: if (t_zero) begin
                    state     <= WR_HOLD;
                    sram_we_n <= 1'b1;
                    wr_done_q <= 1'b1;
                end
                WR_HOLD: begin
                    state     <= IDLE;
                    sram_ce_n <= 1'b1;
                    data_oe   <= 1'b0;
                    wr_done_q <= 1'b0;
                end
                RD_ACCESS: if (t_zero) begin
                    state      <= RD_TURN;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    rd_data_q  <= sram_data;
                    rd_valid_q <= 1'b1;
                end
                RD_TURN: begin
                    state      <= IDLE;
                    rd_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
